// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - two-stage pipelined shift execution unit with valid/ready handshakes

// Logarithmic right shifter; fills with the sign bit when i_arith is set.
module barrel_shifter_r #(
    parameter int XLEN = 64,
    parameter int N    = 6
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [N-1:0]    i_shamt,
    input  logic            i_arith,
    output logic [XLEN-1:0] o_data
);

    logic            w_fill;
    logic [N:0][XLEN-1:0] w_stage;

    assign w_fill     = i_arith & i_data[XLEN-1];
    assign w_stage[0] = i_data;

    // Each level shifts by a power of two selected by one shamt bit.
    for (genvar s = 0; s < N; s++) begin : g_level
        localparam int SH = 1 << s;
        assign w_stage[s+1] = i_shamt[s] ? {{SH{w_fill}}, w_stage[s][XLEN-1:SH]}
                                         : w_stage[s];
    end

    assign o_data = w_stage[N];

endmodule

module shift_unit #(
    parameter  int XLEN = 64,
    localparam int N    = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [N-1:0]    shamt_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] y_o
);

    // W-type operations only exist on the 64-bit datapath.
    localparam logic WORD_OK = (XLEN == 64) ? 1'b1 : 1'b0;

    function automatic logic [XLEN-1:0] f_rev(input logic [XLEN-1:0] x);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = x[XLEN-1-i];
        end
        return r;
    endfunction

    // Stage 1 registers
    logic            r_v1;
    logic [XLEN-1:0] r_opnd1;
    logic [N-1:0]    r_shamt1;
    logic            r_arith1;
    logic            r_left1;
    logic            r_word1;

    // Stage 2 registers
    logic            r_v2;
    logic [XLEN-1:0] r_y;

    // Stage 1 combinational pre-conditioning
    logic            w_word;
    logic            w_arith;
    logic            w_left;
    logic [N-1:0]    w_shamt;
    logic [XLEN-1:0] w_ext;
    logic [XLEN-1:0] w_opnd;

    // Stage 2 combinational post-conditioning
    logic [XLEN-1:0] w_shr;
    logic [XLEN-1:0] w_unrev;
    logic [XLEN-1:0] w_y;

    // Flow control
    logic            w_s2_load;
    logic            w_s1_load;

    assign w_s2_load = !r_v2 || ready_i;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign ready_o   = w_s1_load;
    assign valid_o   = r_v2;
    assign y_o       = r_y;

    // Decode: only 11 is arithmetic; 00 and reserved 10 are left shifts.
    assign w_word  = word_i & WORD_OK;
    assign w_arith = (op_i == 2'b11);
    assign w_left  = !op_i[0];

    // Mask the top shamt bit for W ops so they shift by at most 31.
    always_comb begin
        w_shamt = '0;
        for (int i = 0; i < N; i++) begin
            w_shamt[i] = shamt_i[i] & !(w_word && (i >= 5));
        end
    end

    // Extend the low word to full width: sign copies for SRAW, zeros otherwise.
    always_comb begin
        w_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (w_word && (i >= 32)) begin
                w_ext[i] = w_arith & a_i[31];
            end else begin
                w_ext[i] = a_i[i];
            end
        end
    end

    // Left shifts reuse the right shifter by reversing around it.
    assign w_opnd = w_left ? f_rev(w_ext) : w_ext;

    barrel_shifter_r #(
        .XLEN (XLEN),
        .N    (N)
    ) u_shifter (
        .i_data  (r_opnd1),
        .i_shamt (r_shamt1),
        .i_arith (r_arith1),
        .o_data  (w_shr)
    );

    assign w_unrev = r_left1 ? f_rev(w_shr) : w_shr;

    // W results are sign-extended from bit 31 regardless of direction.
    always_comb begin
        w_y = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (r_word1 && (i >= 32)) begin
                w_y[i] = w_unrev[31];
            end else begin
                w_y[i] = w_unrev[i];
            end
        end
    end

    // Stage 1: capture the pre-conditioned request when the stage may advance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v1     <= 1'b0;
            r_opnd1  <= '0;
            r_shamt1 <= '0;
            r_arith1 <= 1'b0;
            r_left1  <= 1'b0;
            r_word1  <= 1'b0;
        end else if (w_s1_load) begin
            r_v1 <= valid_i;
            if (valid_i) begin
                r_opnd1  <= w_opnd;
                r_shamt1 <= w_shamt;
                r_arith1 <= w_arith;
                r_left1  <= w_left;
                r_word1  <= w_word;
            end
        end
    end

    // Stage 2: register the corrected result; hold it while the consumer stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_v2 <= 1'b0;
            r_y  <= '0;
        end else if (w_s2_load) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_y <= w_y;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - self-checking bench for shift_unit with reference model

module tb_shift_unit;

    logic        clock;
    logic        reset;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic        word_i;
    logic [63:0] a_i;
    logic [5:0]  shamt_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] y_o;

    int n_checks;
    int n_errors;

    shift_unit #(.XLEN(64)) dut (
        .clock   (clock),
        .reset   (reset),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .op_i    (op_i),
        .word_i  (word_i),
        .a_i     (a_i),
        .shamt_i (shamt_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .y_o     (y_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural shift semantics written directly from the operation rules.
    function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [5:0] sh);
        logic [31:0] a32;
        logic [31:0] r32;
        logic [4:0]  s5;
        if (w) begin
            a32 = a[31:0];
            s5  = sh[4:0];
            if (op == 2'b11)      r32 = $unsigned($signed(a32) >>> s5);
            else if (op == 2'b01) r32 = a32 >> s5;
            else                  r32 = a32 << s5;
            return {{32{r32[31]}}, r32};
        end
        if (op == 2'b11)      return $unsigned($signed(a) >>> sh);
        else if (op == 2'b01) return a >> sh;
        else                  return a << sh;
    endfunction

    task automatic run_one(input string tag, input logic [1:0] op, input logic w,
                           input logic [63:0] a, input logic [5:0] sh, input logic [63:0] exp);
        @(negedge clock);
        ready_i = 1'b1; valid_i = 1'b1; op_i = op; word_i = w; a_i = a; shamt_i = sh;
        #1 check({tag, "_rdy"}, {63'd0, ready_o}, 64'd1);
        @(posedge clock);
        @(negedge clock);
        valid_i = 1'b0;
        #1 check({tag, "_early"}, {63'd0, valid_o}, 64'd0);
        @(posedge clock);
        @(negedge clock);
        #1 check({tag, "_vld"}, {63'd0, valid_o}, 64'd1);
        check(tag, y_o, exp);
        @(posedge clock);
    endtask

    logic [63:0] exp_q[$];
    logic [63:0] bp_exp[4];
    logic [63:0] prev_y;
    logic        hold;
    int          acc;
    int          outs;
    logic [1:0]  r_op;
    logic        r_w;

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        op_i = 2'b00; word_i = 1'b0; a_i = '0; shamt_i = '0;

        // Reset state
        repeat (2) @(negedge clock);
        #1 check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_y", y_o, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("rst_ready", {63'd0, ready_o}, 64'd1);

        // Directed cases from the test plan
        run_one("srl63",  2'b01, 1'b0, 64'h8000_0000_0000_0000, 6'd63, 64'h1);
        run_one("sra4",   2'b11, 1'b0, 64'hF000_0000_0000_0000, 6'd4,  64'hFF00_0000_0000_0000);
        run_one("sll63",  2'b00, 1'b0, 64'h1,                   6'd63, 64'h8000_0000_0000_0000);
        run_one("rsv",    2'b10, 1'b0, 64'h3,                   6'd1,  64'h6);
        run_one("sraw31", 2'b11, 1'b1, 64'h0000_0000_8000_0000, 6'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        run_one("srlw31", 2'b01, 1'b1, 64'h0000_0000_8000_0000, 6'd31, 64'h1);
        run_one("sllw63", 2'b00, 1'b1, 64'h1,                   6'd63, 64'hFFFF_FFFF_8000_0000);
        run_one("srlw0",  2'b01, 1'b1, 64'h0000_0000_8000_0000, 6'd0,  64'hFFFF_FFFF_8000_0000);
        run_one("sra0",   2'b11, 1'b0, 64'h8123_4567_89AB_CDEF, 6'd0,  64'h8123_4567_89AB_CDEF);

        // Backpressure: four SRLs of 0x10, consumer stalled for three cycles
        for (int i = 0; i < 4; i++) bp_exp[i] = 64'h10 >> i;
        acc = 0; outs = 0;
        for (int cyc = 0; cyc < 40 && outs < 4; cyc++) begin
            @(negedge clock);
            ready_i = (cyc >= 5);
            valid_i = (acc < 4);
            op_i = 2'b01; word_i = 1'b0; a_i = 64'h10; shamt_i = acc[5:0];
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                check("bp_rdy_low", {63'd0, ready_o}, 64'd0);
                check("bp_hold_y", y_o, 64'h10);
            end
            if (cyc == 2) check("bp_accepts", acc, 64'd2);
            if (valid_o && ready_i) begin
                check("bp_out", y_o, bp_exp[outs]);
                outs++;
            end
            if (valid_i && ready_o) acc++;
            @(posedge clock);
        end
        check("bp_outs", outs, 64'd4);
        @(negedge clock);
        valid_i = 1'b0;
        #1 check("bp_rdy_end", {63'd0, ready_o}, 64'd1);

        // Reset with both stages full
        ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            valid_i = 1'b1; op_i = 2'b01; word_i = 1'b0; a_i = 64'hABCD; shamt_i = 6'd0;
            @(posedge clock);
        end
        @(negedge clock);
        valid_i = 1'b0;
        #1 check("mr_full", {63'd0, ready_o}, 64'd0);
        #1 reset = 1'b0;
        #1 check("mr_valid", {63'd0, valid_o}, 64'd0);
        check("mr_y", y_o, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        ready_i = 1'b1;
        #1 check("mr_ready", {63'd0, ready_o}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1 check("mr_stale", {63'd0, valid_o}, 64'd0);
        end

        // Randomized traffic against the reference model
        hold = 1'b0; prev_y = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            if (hold) check("rnd_stable", y_o, prev_y);
            r_op = 2'($urandom_range(0, 3));
            r_w  = 1'($urandom_range(0, 1));
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            op_i = r_op; word_i = r_w;
            a_i = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a_i = 64'h8000_0000_8000_0000;
            shamt_i = 6'($urandom_range(0, 63));
            #1;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) check("rnd_extra", 64'd1, 64'd0);
                else check("rnd_y", y_o, exp_q.pop_front());
            end
            if (valid_i && ready_o) exp_q.push_back(ref_shift(op_i, word_i, a_i, shamt_i));
            hold = valid_o && !ready_i;
            prev_y = y_o;
            @(posedge clock);
        end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clock);
            valid_i = 1'b0; ready_i = 1'b1;
            #1;
            if (valid_o) begin
                if (exp_q.size() == 0) check("drain_extra", 64'd1, 64'd0);
                else check("drain_y", y_o, exp_q.pop_front());
            end
            @(posedge clock);
        end
        check("rnd_left", exp_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Pipelined shift execution unit for the ULA. It accepts a shift operation over a valid/ready handshake, pre-conditions the operand, and drives one `barrel_shifter_r` instance. Left shifts go through bit reversal, and RV64 W-type ops go through 32-bit extension. It returns the registered, sign-corrected result two cycles later over a second valid/ready handshake. It sits between instruction issue and writeback and sustains one operation per cycle.

## Interface
- `XLEN`, default 64, is the data width. Legal values are 32 and 64. `N = log2(XLEN)` is derived internally and passed to `barrel_shifter_r`.
- `clock`, input, 1 bit: single clock. All state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `valid_i`, input, 1 bit: request valid.
- `ready_o`, output, 1 bit: unit can accept a request this cycle.
- `op_i`, input, 2 bits: operation select.
  - `00` is SLL.
  - `01` is SRL.
  - `11` is SRA.
  - `10` is reserved and executes as SLL.
- `word_i`, input, 1 bit: W-type operation. Ignored when `XLEN=32`.
- `a_i`, input, XLEN bits: operand.
- `shamt_i`, input, N bits: shift amount.
- `valid_o`, output, 1 bit: result valid.
- `ready_i`, input, 1 bit: consumer accepts the result.
- `y_o`, output, XLEN bits: result.

## Operation
- A request transfers on an edge where `valid_i && ready_o`. A result transfers on an edge where `valid_o && ready_i`.
- Stage 1 pre-conditions the operand and registers `opnd1`, `shamt1`, `arith1`, `left1`, `word1`, and `v1`.
  - Effective shamt is `shamt_i` if `word_i=0`, else `{0, shamt_i[4:0]}` (upper bit masked).
  - For W-type with XLEN=64, the operand is `{32{a_i[31]}, a_i[31:0]}` for SRA and `{32'b0, a_i[31:0]}` otherwise.
  - For SLL and reserved, the operand is bit-reversed and the shifter runs logical.
  - `arithmetic` is 1 only for op `11`.
- Between stages, `barrel_shifter_r` combinationally shifts `opnd1` right by `shamt1`.
- Stage 2 post-conditions the shifter output and registers `y_o` and `v2` (`v2` is `valid_o`).
  - Left ops: the shifter output is bit-reversed back.
  - Word ops: the final value is `{32{r[31]}, r[31:0]}`, sign-extended from bit 31 for all three W ops.
- The shifter always sees full XLEN width. A W-type SRA shifts in copies of bit 31 through the pre-extension.
- Flow control:
  - Stage 2 loads when `!v2 || ready_i`. It loads `v1` and the stage-1 result.
  - Stage 1 loads when `!v1 || stage2_loads`.
  - `ready_o = !v1 || stage2_loads`, combinational from `ready_i`.
- `y_o` is stable while `valid_o && !ready_i`.
- Stage registers do not change when their valid is low and they are not loading. The data registers may also be left unchanged when the stage loads invalid data.
- Requests complete in order. No request is dropped or duplicated.

## Timing
- Reset (asynchronous, `reset=0`):
  - `v1=0`, `v2=0`, `valid_o=0`.
  - `y_o=0`, and all stage data registers are 0.
  - `ready_o=1` as soon as reset is released.
- Latency: a request accepted at edge k presents `valid_o=1` after edge k+1, provided no backpressure.
- Throughput: one operation per cycle while `ready_i=1`.
- Backpressure:
  - With `ready_i=0` the pipe holds up to 2 operations.
  - `ready_o` falls in the cycle where `v1 && v2 && !ready_i`.
- Simultaneous accept and drain in the same cycle is legal and keeps throughput at one per cycle.
- Reset mid-operation discards all in-flight operations. `valid_o` drops asynchronously. Nothing is replayed.
- Boundaries:
  - `shamt=0` returns the operand unchanged; for W ops the value is sign-extended from bit 31.
  - `shamt=XLEN-1` is the maximal shift.
  - W ops with `shamt_i[5]=1` use only the low 5 bits.

## Test plan
- **SRL**, XLEN=64: `a=0x8000_0000_0000_0000`, `shamt=63`. Required: `y=0x1`, with `valid_o` high 2 edges after accept.
- **SRA**: `a=0xF000_0000_0000_0000`, `shamt=4`. Required: `y=0xFF00_0000_0000_0000`.
- **SLL**: `a=0x1`, `shamt=63`. Required: `y=0x8000_0000_0000_0000`.
- **Reserved op `10`**: `a=0x3`, `shamt=1`. Required: `0x6`.
- **W ops**, all with `a=0x0000_0000_8000_0000` except SLLW:
  - SRAW, `shamt=31`: `y=0xFFFF_FFFF_FFFF_FFFF`.
  - SRLW, `shamt=31`: `y=0x1`.
  - SLLW, `a=0x1`, `shamt_i=63`: `y=0xFFFF_FFFF_8000_0000` (shamt masked to 31).
  - SRLW, `shamt=0`: `y=0xFFFF_FFFF_8000_0000`.
- **Backpressure**:
  - Stimulus: issue 4 back-to-back SRLs of `0x10` with shamt 0..3, hold `ready_i=0` for 3 cycles, then raise it.
  - Required: `ready_o` falls after 2 accepts and `y_o` holds `0x10` while stalled.
  - Required: outputs `0x10`, `0x8`, `0x4`, `0x2` in order, then `ready_o=1`.
- **Reset mid-operation**: pulse `reset` low with both stages full. Required: `valid_o=0` and `y_o=0` before the next clock edge, no stale result after release, and `ready_o=1`.
